// File: rtl/button_conditioner_pkg.sv
// Shared defaults and limits for the button conditioner (package button_cond_pkg).
// The BTN_DEBOUNCE_EN macro selects the debounced build. The package itself does not depend on it.
package button_cond_pkg;
    localparam int DEFAULT_CHANNELS        = 2;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int MIN_SYNC_STAGES         = 2;
endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchronizer chain, optional debounce counter (BTN_DEBOUNCE_EN),
// a registered level, and one-cycle press/release pulses aligned with the level change.
module btn_debounce_ch
    import button_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);
    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $error("btn_debounce_ch: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("btn_debounce_ch: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   sync_w;

    assign sync_w = sync_q[SYNC_STAGES-1];

`ifdef BTN_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          toggle;

    // The counter only runs while the synchronized input disagrees with level.
    // Agreement on any cycle discards the partial count.
    always_comb begin
        cnt_d  = '0;
        toggle = 1'b0;
        if (sync_w != level_q) begin
            if (cnt_q == CNT_LAST) begin
                toggle = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        level_d = level_q ^ toggle;
    end
`else
    always_comb begin
        level_d = sync_w;
    end
`endif

    // Pulses are computed from the next level so they appear together with it.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], push_i};
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner. Define BTN_DEBOUNCE_EN to enable the debounce counters.
// "release" is a reserved word, so the 1->0 pulse port is named release_o.
module button_conditioner
    import button_cond_pkg::*;
#(
    parameter int CHANNELS        = DEFAULT_CHANNELS,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] push,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_o
);
    if (CHANNELS < 1) begin : g_bad_channels
        $error("button_conditioner: CHANNELS must be >= 1");
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        btn_debounce_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .push_i   (push[g]),
            .level_o  (level[g]),
            .press_o  (press[g]),
            .release_o(release_o[g])
        );
    end
endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Expectations follow BTN_DEBOUNCE_EN in the same way as the design.
module tb_button_conditioner;
    localparam int CH   = 2;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
`ifdef BTN_DEBOUNCE_EN
    localparam int LAT = SYNC + DEB;
`else
    localparam int LAT = SYNC + 1;
`endif

    // clock / reset
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] push = '0;
    logic [CH-1:0] level, press, release_o;

    always #5 clk = ~clk;

    button_conditioner #(
        .CHANNELS(CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .rst(rst), .push(push),
        .level(level), .press(press), .release_o(release_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Reference model: sync is push delayed by SYNC edges. Level flips once sync has
    // disagreed with it for DEB consecutive edges (debounced) or follows sync one edge later.
    logic [CH-1:0] exp_q[$];
    logic [CH-1:0] m_lvl, m_press, m_rel;
    int            m_run[CH];

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < SYNC; i++) exp_q.push_back('0);
        m_lvl = '0; m_press = '0; m_rel = '0;
        for (int c = 0; c < CH; c++) m_run[c] = 0;
    endtask

    task automatic model_step(input logic [CH-1:0] p);
        logic [CH-1:0] old_sync, nxt;
        old_sync = exp_q[SYNC-1];
        nxt = m_lvl;
        for (int c = 0; c < CH; c++) begin
`ifdef BTN_DEBOUNCE_EN
            if (old_sync[c] != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == DEB) begin
                    nxt[c] = ~m_lvl[c];
                    m_run[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
`else
            nxt[c] = old_sync[c];
`endif
        end
        m_press = nxt & ~m_lvl;
        m_rel   = ~nxt & m_lvl;
        m_lvl   = nxt;
        exp_q.push_front(p);
        void'(exp_q.pop_back());
    endtask

    // driver: apply push, take one rising edge, then compare with the model
    task automatic tick(input logic [CH-1:0] p);
        push = p;
        @(posedge clk);
        model_step(p);
        #1;
        check("model_level", level, m_lvl);
        check("model_press", press, m_press);
        check("model_release", release_o, m_rel);
        check("press_and_release", press & release_o, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("rst_level", level, '0);
        check("rst_press", press, '0);
        check("rst_release", release_o, '0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [CH-1:0] push;
        logic [CH-1:0] level;
        logic [CH-1:0] press;
    } vec_t;
    vec_t vecs[10];

    int n_press, n_rel, edge_at;
    logic [CH-1:0] cur;
    int hold[CH];

    initial begin
        for (int k = 0; k < 10; k++) begin
            vecs[k].push  = 2'b01;
            vecs[k].level = (k + 1 >= LAT) ? 2'b01 : 2'b00;
            vecs[k].press = (k + 1 == LAT) ? 2'b01 : 2'b00;
        end
        model_reset();

        // single rise on channel 0: level after edge LAT, press exactly that cycle
        do_reset();
        for (int k = 0; k < 10; k++) begin
            tick(vecs[k].push);
            check("vec_level", level, vecs[k].level);
            check("vec_press", press, vecs[k].press);
            check("vec_release", release_o, '0);
        end

        // short excursion on channel 1
        do_reset();
        n_press = 0; n_rel = 0;
        for (int k = 0; k < 12; k++) begin
            tick(k < 3 ? 2'b10 : 2'b00);
            if (press[1]) n_press++;
            if (release_o[1]) n_rel++;
`ifdef BTN_DEBOUNCE_EN
            check("glitch_level1", {1'b0, level[1]}, '0);
`endif
        end
`ifdef BTN_DEBOUNCE_EN
        check("glitch_press_cnt", n_press[CH-1:0], '0);
        check("glitch_release_cnt", n_rel[CH-1:0], '0);
`endif

        // bouncing channel 0: 1,0,1,1,1,...
        do_reset();
        n_press = 0; edge_at = 0;
        for (int k = 1; k <= 14; k++) begin
            tick(k == 2 ? 2'b00 : 2'b01);
            if (press[0]) begin
                n_press++;
                if (edge_at == 0) edge_at = k;
            end
        end
`ifdef BTN_DEBOUNCE_EN
        check("bounce_press_cnt", n_press[CH-1:0], 2'd1);
        check("bounce_rise_edge", edge_at[CH-1:0], 2'(8));
        check("bounce_level", level, 2'b01);
`endif

        // both channels together
        do_reset();
        n_press = 0; n_rel = 0;
        for (int k = 0; k < 20; k++) begin
            tick(k < 10 ? 2'b11 : 2'b00);
            if (press == 2'b11) n_press++;
            if (release_o == 2'b11) n_rel++;
        end
        check("both_press_cnt", n_press[CH-1:0], 2'd1);
        check("both_release_cnt", n_rel[CH-1:0], 2'd1);

        // reset in the middle of a debounce interval, push held high
        do_reset();
        for (int k = 0; k < 4; k++) tick(2'b01);
`ifdef BTN_DEBOUNCE_EN
        check("mid_level_before_rst", level, '0);
`endif
        do_reset();
        n_press = 0; edge_at = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(2'b01);
            if (press[0]) begin
                n_press++;
                if (edge_at == 0) edge_at = k;
            end
        end
        check("rst_press_cnt", n_press[CH-1:0], 2'd1);
        check("rst_press_edge", edge_at[3:0] == LAT[3:0] ? 2'b01 : 2'b00, 2'b01);

        // random holds of 1..8 cycles per channel against the model
        do_reset();
        cur = '0;
        for (int c = 0; c < CH; c++) hold[c] = 0;
        for (int k = 0; k < 800; k++) begin
            for (int c = 0; c < CH; c++) begin
                if (hold[c] == 0) begin
                    cur[c]  = 1'($urandom_range(0, 1));
                    hold[c] = $urandom_range(1, 8);
                end
                hold[c]--;
            end
            tick(cur);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of independent push inputs (>=1).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops per channel (>=2).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles required before level change (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all flops rising-edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port push  input  CHANNELS  raw asynchronous button inputs, bit i = channel i.
REQ-007 SHALL have port level  output  CHANNELS  conditioned (synchronized, debounced) button state.
REQ-008 SHALL have port press  output  CHANNELS  one-cycle pulse on level 0->1.
REQ-009 SHALL have port release  output  CHANNELS  one-cycle pulse on level 1->0.

Function
REQ-010 SHALL pass each push bit through a SYNC_STAGES-deep flop chain; chain output is sync[i].
REQ-011 SHALL, per channel, hold a counter of width clog2(DEBOUNCE_CYCLES+1), cleared on any cycle where sync[i]==level[i].
REQ-012 SHALL increment the counter on each edge where sync[i]!=level[i] and counter<DEBOUNCE_CYCLES-1.
REQ-013 SHALL, on the edge where sync[i]!=level[i] and counter==DEBOUNCE_CYCLES-1, toggle level[i] and clear the counter.
REQ-014 SHALL give latency from push stable (before edge 1) to level change of exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges.
REQ-015 SHALL ignore any sync[i] excursion shorter than DEBOUNCE_CYCLES cycles: no level change, no pulse, counter restarts from 0.
REQ-016 SHALL register press[i] and release[i] so each is high in exactly the first cycle level[i] holds its new value, low otherwise.
REQ-017 SHALL never assert press[i] and release[i] in the same cycle.
REQ-018 SHALL treat channels independently; simultaneous transitions on several channels produce simultaneous pulses.
REQ-019 SHALL never let the counter exceed DEBOUNCE_CYCLES-1 (no wrap).

Reset
REQ-020 SHALL, while rst is high, clear all sync flops, counters, level, press, release to 0 asynchronously.
REQ-021 SHALL, after rst deassertion with push held high, produce no pulse until full REQ-014 latency elapses, then press once.
REQ-022 SHALL discard any partially counted debounce interval when rst asserts mid-operation.

Configuration
REQ-023 SHALL use macro BTN_DEBOUNCE_EN to compile in the debounce counters.
REQ-024 SHALL, with BTN_DEBOUNCE_EN defined, behave per REQ-011..REQ-015.
REQ-025 SHALL, without BTN_DEBOUNCE_EN, omit counters, ignore DEBOUNCE_CYCLES, and register level[i]<=sync[i] each edge (latency SYNC_STAGES+1); press/release per REQ-016.

Structure
REQ-026 SHALL place default constants (channel count, sync stages, debounce cycles) and minimum-stage constant in shared package button_cond_pkg.
REQ-027 SHALL implement one channel (sync chain, counter, level, edge pulses) as sub-module btn_debounce_ch, instantiated CHANNELS times via generate.
REQ-028 SHALL flag parameter violations (SYNC_STAGES<2, DEBOUNCE_CYCLES<1, CHANNELS<1) at elaboration.

Verification (CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, macro defined unless stated)
REQ-029 SHALL cover: push[0] 0->1 held -> level[0] high after edge 6, press[0] high only cycle following edge 6.
REQ-030 SHALL cover: push[1] high for 3 cycles then low -> level[1] stays 0, press/release never assert.
REQ-031 SHALL cover: push[0] bouncing 1,0,1,1,1,1 per cycle -> level[0] rises 4 edges after final stable 1 reaches sync, single press.
REQ-032 SHALL cover: both channels rise same cycle, later both fall -> press=2'b11 one cycle, release=2'b11 one cycle.
REQ-033 SHALL cover: rst pulsed after 2 debounce counts with push held -> outputs 0, press appears 6 edges after rst release.
REQ-034 SHALL cover: macro undefined, push[0] 0->1 -> level[0] high after edge 3, press[0] one cycle.
